// File: rtl/texture_buffer_nd.sv
// texture_buffer_nd
//   Holds one RGBA4444 texture loaded over AXI-Stream and returns one texel
//   per clock to the texel pipeline with a fixed 2-cycle latency.
//   Texture width/height are independent powers of two (up to 256x256), and
//   each axis can wrap or clamp.
//
// Ports
//   clk, reset         single clock; asynchronous active-high reset
//   widthLog2/heightLog2  texture size as log2 (0..8), static during reads
//   clampS/clampT      1 = clamp the axis, 0 = wrap it
//   texelReq           read request qualifier
//   texelIndex         {T, S}, each unsigned Q1.15
//   texel/texelValid   RGBA4444 result, valid 2 cycles after texelReq
//   textureReady       a complete texture is resident
//   overflow           the last stream carried more than DEPTH beats
//   s_axis_*           write stream; lane 0 = lowest texel address
module texture_buffer_nd #(
  parameter int STREAM_WIDTH = 64,
  parameter int SIZE         = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              widthLog2,
  input  logic [3:0]              heightLog2,
  input  logic                    clampS,
  input  logic                    clampT,
  input  logic                    texelReq,
  input  logic [31:0]             texelIndex,
  output logic [15:0]             texel,
  output logic                    texelValid,
  output logic                    textureReady,
  output logic                    overflow,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0] s_axis_tdata
);

  localparam int PPB    = STREAM_WIDTH / 16;
  localparam int LANE_W = (PPB > 1) ? $clog2(PPB) : 0;
  localparam int LSEL_W = (LANE_W > 0) ? LANE_W : 1;
  localparam int DEPTH  = (2 ** SIZE) / (STREAM_WIDTH / 8);
  localparam int AW     = $clog2(DEPTH);
  localparam int IW     = SIZE - 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  // Texel coordinate for one axis: the n fraction bits just below the
  // integer bit. Wrap simply ignores the integer bit; clamp saturates
  // when it is set.
  function automatic logic [7:0] axis_int(input logic [15:0] c,
                                          input logic [3:0]  n,
                                          input logic        clamp);
    logic [15:0] mask;
    logic [15:0] v;
    mask = (16'd1 << n) - 16'd1;
    if (clamp && c[15]) v = mask;
    else                v = (c >> (5'd15 - {1'b0, n})) & mask;
    return v[7:0];
  endfunction

  // Read side
  logic [7:0]              w_s;
  logic [7:0]              w_t;
  logic [IW-1:0]           w_index;
  logic [AW-1:0]           w_word;
  logic [LSEL_W-1:0]       w_lane;

  logic [STREAM_WIDTH-1:0] r_mem [DEPTH];
  logic [STREAM_WIDTH-1:0] r_rdata;
  logic [LSEL_W-1:0]       r_lane;
  logic                    r_req1;
  logic [15:0]             r_texel;
  logic                    r_texel_valid;

  // Write side
  state_t                  r_state;
  state_t                  w_nstate;
  logic [AW-1:0]           r_waddr;
  logic [AW-1:0]           w_naddr;
  logic                    r_ready;
  logic                    w_nready;
  logic                    r_ovf;
  logic                    w_novf;
  logic                    w_we;

  assign w_s     = (widthLog2  == 4'd0) ? '0 : axis_int(texelIndex[15:0],  widthLog2,  clampS);
  assign w_t     = (heightLog2 == 4'd0) ? '0 : axis_int(texelIndex[31:16], heightLog2, clampT);
  assign w_index = IW'(({24'd0, w_t} << widthLog2) | {24'd0, w_s});
  assign w_word  = AW'(w_index >> LANE_W);
  assign w_lane  = LSEL_W'(w_index & IW'(PPB - 1));

  // Read-first RAM: the read samples the array before this edge's write.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_waddr] <= s_axis_tdata;
    r_rdata <= r_mem[w_word];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lane        <= '0;
      r_req1        <= 1'b0;
      r_texel       <= '0;
      r_texel_valid <= 1'b0;
    end else begin
      r_lane        <= w_lane;
      r_req1        <= texelReq;
      r_texel_valid <= r_req1;
      if (r_req1) r_texel <= r_rdata[16*r_lane +: 16];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_waddr <= '0;
      r_ready <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_waddr <= w_naddr;
      r_ready <= w_nready;
      r_ovf   <= w_novf;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_naddr  = r_waddr;
    w_nready = r_ready;
    w_novf   = r_ovf;
    w_we     = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_axis_tvalid) begin
          w_we     = 1'b1;
          w_nready = 1'b0;
          w_novf   = 1'b0;
          if (s_axis_tlast) begin
            w_naddr  = '0;
            w_nready = 1'b1;
          end else begin
            w_naddr  = AW'(1);
            w_nstate = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_axis_tvalid) begin
          w_we = 1'b1;
          if (s_axis_tlast) begin
            w_naddr  = '0;
            w_nready = 1'b1;
            w_nstate = IDLE;
          end else if (r_waddr == AW'(DEPTH - 1)) begin
            w_novf   = 1'b1;
            w_nstate = DRAIN;
          end else begin
            w_naddr = r_waddr + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          w_naddr  = '0;
          w_nready = 1'b1;
          w_nstate = IDLE;
        end
      end
      default: w_nstate = IDLE;
    endcase
    // The stream is never backpressured, so beats arriving while reset is
    // held must not reach the RAM.
    if (reset) w_we = 1'b0;
  end

  assign s_axis_tready = 1'b1;
  assign textureReady  = r_ready;
  assign overflow      = r_ovf;
  assign texel         = r_texel;
  assign texelValid    = r_texel_valid;

endmodule

// File: tb/tb_texture_buffer_nd.sv
module tb_texture_buffer_nd;
  localparam int SW    = 64;
  localparam int DEP_B = 16384;   // SIZE=17
  localparam int DEP_S = 256;     // SIZE=11

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] wl, hl;
  logic cs, ct;

  logic b_req, b_valid, b_ready, b_ovf, b_tvalid, b_tready, b_tlast;
  logic [31:0] b_idx;
  logic [15:0] b_texel;
  logic [SW-1:0] b_tdata;
  logic s_req, s_valid, s_ready, s_ovf, s_tvalid, s_tready, s_tlast;
  logic [31:0] s_idx;
  logic [15:0] s_texel;
  logic [SW-1:0] s_tdata;

  texture_buffer_nd #(.STREAM_WIDTH(SW), .SIZE(17)) u_big (
    .clk(clk), .reset(rst), .widthLog2(wl), .heightLog2(hl), .clampS(cs), .clampT(ct),
    .texelReq(b_req), .texelIndex(b_idx), .texel(b_texel), .texelValid(b_valid),
    .textureReady(b_ready), .overflow(b_ovf), .s_axis_tvalid(b_tvalid),
    .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tdata(b_tdata));

  texture_buffer_nd #(.STREAM_WIDTH(SW), .SIZE(11)) u_small (
    .clk(clk), .reset(rst), .widthLog2(wl), .heightLog2(hl), .clampS(cs), .clampT(ct),
    .texelReq(s_req), .texelIndex(s_idx), .texel(s_texel), .texelValid(s_valid),
    .textureReady(s_ready), .overflow(s_ovf), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tdata(s_tdata));

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: texel-addressed memories and per-stream bookkeeping.
  typedef struct { logic [15:0] val; int cyc; } exp_t;
  exp_t q_b[$];
  exp_t q_s[$];
  logic [15:0] mem_b [65536];
  logic [15:0] mem_s [1024];
  int cnt[2];
  bit m_ready[2];
  bit m_ovf[2];

  function automatic int ax(int c, int n, bit cl);
    if (n == 0) return 0;
    if (cl && c >= 32768) return (1 << n) - 1;
    return ((c % 32768) * (1 << n)) / 32768;
  endfunction

  function automatic logic [15:0] model_read(bit sel, logic [31:0] idx);
    int si, ti, lin;
    si  = ax(int'(idx[15:0]),  int'(wl), cs);
    ti  = ax(int'(idx[31:16]), int'(hl), ct);
    lin = ti * (1 << int'(wl)) + si;
    return sel ? mem_s[lin % 1024] : mem_b[lin % 65536];
  endfunction

  task automatic model_beat(bit sel, logic [63:0] d, bit last);
    int k, dep;
    k   = cnt[sel];
    dep = sel ? DEP_S : DEP_B;
    if (k < dep)
      for (int l = 0; l < 4; l++) begin
        if (sel) mem_s[k*4 + l] = d[16*l +: 16];
        else     mem_b[k*4 + l] = d[16*l +: 16];
      end
    if (k == 0) begin m_ready[sel] = 0; m_ovf[sel] = 0; end
    cnt[sel] = k + 1;
    if (last) begin
      m_ready[sel] = 1;
      m_ovf[sel]   = (cnt[sel] > dep);
      cnt[sel]     = 0;
    end else begin
      m_ovf[sel] = (cnt[sel] >= dep);
    end
  endtask

  function automatic logic [63:0] pack4(int base, logic [15:0] xr);
    logic [63:0] d;
    for (int l = 0; l < 4; l++) d[16*l +: 16] = 16'(base + l) ^ xr;
    return d;
  endfunction

  // Index that lands on texel address a for a wl x hl wrap texture, with
  // random sub-texel fraction bits.
  function automatic logic [31:0] mk_idx(int a, int w, int h);
    logic [15:0] s, t;
    s = 16'(((a & ((1 << w) - 1)) << (15 - w)) | ($urandom & ((1 << (15 - w)) - 1)));
    t = 16'(((a >> w) << (15 - h)) | ($urandom & ((1 << (15 - h)) - 1)));
    return {t, s};
  endfunction

  // One clock of stimulus; expectations use memory contents before this
  // cycle's write (read-first).
  task automatic step(bit sel, bit req, logic [31:0] idx, bit vld, bit last, logic [63:0] d);
    exp_t e;
    if (req) begin
      e.val = model_read(sel, idx);
      e.cyc = cyc;
      if (sel) q_s.push_back(e); else q_b.push_back(e);
    end
    if (vld) model_beat(sel, d, last);
    b_req = !sel && req;  b_idx = idx;  b_tvalid = !sel && vld;  b_tlast = last;  b_tdata = d;
    s_req = sel && req;   s_idx = idx;  s_tvalid = sel && vld;   s_tlast = last;  s_tdata = d;
    @(posedge clk); #1;
    if (!rst) begin
      chk("b_textureReady", 32'(b_ready), 32'(m_ready[0]));
      chk("b_overflow",     32'(b_ovf),   32'(m_ovf[0]));
      chk("s_textureReady", 32'(s_ready), 32'(m_ready[1]));
      chk("s_overflow",     32'(s_ovf),   32'(m_ovf[1]));
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic stream(bit sel, int n, logic [15:0] xr);
    for (int b = 0; b < n; b++) step(sel, 0, 0, 1, b == n - 1, pack4(4*b, xr));
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_b_ready"}, 32'(b_ready), 0);
    chk({tag, "_b_ovf"},   32'(b_ovf),   0);
    chk({tag, "_b_valid"}, 32'(b_valid), 0);
    chk({tag, "_b_texel"}, 32'(b_texel), 0);
    chk({tag, "_b_tready"}, 32'(b_tready), 1);
    chk({tag, "_s_ready"}, 32'(s_ready), 0);
    chk({tag, "_s_ovf"},   32'(s_ovf),   0);
    chk({tag, "_s_valid"}, 32'(s_valid), 0);
    chk({tag, "_s_texel"}, 32'(s_texel), 0);
    chk({tag, "_s_tready"}, 32'(s_tready), 1);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (b_valid) begin
        if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
        else begin
          e = q_b.pop_front();
          chk("b_texel", 32'(b_texel), 32'(e.val));
          chk("b_latency", 32'(cyc - e.cyc), 2);
        end
      end
      if (s_valid) begin
        if (q_s.size() == 0) chk("s_unexpected_valid", 1, 0);
        else begin
          e = q_s.pop_front();
          chk("s_texel", 32'(s_texel), 32'(e.val));
          chk("s_latency", 32'(cyc - e.cyc), 2);
        end
      end
    end
  end

  initial begin
    int hmax;
    rst = 1'b1;
    wl = 4'd5; hl = 4'd5; cs = 0; ct = 0;
    b_req = 0; b_idx = 0; b_tvalid = 0; b_tlast = 0; b_tdata = 0;
    s_req = 0; s_idx = 0; s_tvalid = 0; s_tlast = 0; s_tdata = 0;
    cnt[0] = 0; cnt[1] = 0; m_ready[0] = 0; m_ready[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    repeat (3) @(posedge clk);
    #1 reset_checks("rst0");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // 32x32 texture, texel value = address
    stream(0, 256, 16'h0000);
    step(0, 1, {16'h2000, 16'h4000}, 0, 0, 0);
    idle(3);
    // wrap vs clamp on S
    step(0, 1, {16'h0000, 16'h8400}, 0, 0, 0);
    idle(3);
    cs = 1;
    step(0, 1, {16'h0000, 16'h8400}, 0, 0, 0);
    idle(3);
    cs = 0;
    // non-square 64x16
    wl = 4'd6; hl = 4'd4;
    step(0, 1, {16'h7800, 16'h0000}, 0, 0, 0);
    idle(3);
    ct = 1;
    step(0, 1, {16'hFFFF, 16'h0000}, 0, 0, 0);
    idle(3);
    ct = 0;
    // random shapes and indices inside the loaded 1024 texels
    for (int g = 0; g < 20; g++) begin
      wl = 4'($urandom_range(0, 8));
      hmax = 10 - int'(wl);
      if (hmax > 8) hmax = 8;
      hl = 4'($urandom_range(0, hmax));
      cs = 1'($urandom); ct = 1'($urandom);
      for (int r = 0; r < 10; r++) begin
        step(0, 1, $urandom, 0, 0, 0);
        if ($urandom_range(0, 2) == 0) idle(1);
      end
      idle(3);
    end

    // overflow on the SIZE=11 instance
    wl = 4'd5; hl = 4'd5; cs = 0; ct = 0;
    stream(1, 300, 16'h0000);
    for (int a = 0; a < 4; a++) step(1, 1, mk_idx(a, 5, 5), 0, 0, 0);
    for (int r = 0; r < 20; r++) step(1, 1, $urandom, 0, 0, 0);
    idle(3);
    stream(1, 1, 16'hFFFF);
    step(1, 1, mk_idx(1, 5, 5), 0, 0, 0);
    idle(3);

    // asynchronous reset mid-stream at writeAddr = 100
    for (int b = 0; b < 100; b++) step(0, 0, 0, 1, 0, pack4(4*b, 16'h1111));
    #3;
    rst = 1'b1;
    b_tvalid = 0; s_tvalid = 0;
    #1 reset_checks("rst_async");
    cnt[0] = 0; cnt[1] = 0; m_ready[0] = 0; m_ready[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    q_b.delete(); q_s.delete();
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    stream(0, 256, 16'h5A5A);
    for (int r = 0; r < 16; r++) step(0, 1, $urandom, 0, 0, 0);
    idle(3);

    // 8 back-to-back reads during a reload; even reads hit the word being
    // written that cycle, odd reads the word written the cycle before
    for (int b = 0; b < 256; b++) begin
      bit rq;
      int k, w;
      rq = (b >= 20 && b < 28);
      k  = b - 20;
      w  = (k % 2 == 0) ? b : b - 1;
      step(0, rq, rq ? mk_idx(w*4 + int'($urandom_range(0, 3)), 5, 5) : 32'd0,
           1, b == 255, pack4(4*b, 16'h3C3C));
    end
    idle(4);

    chk("b_scoreboard_empty", 32'(q_b.size()), 0);
    chk("s_scoreboard_empty", 32'(q_s.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/texture_buffer_nd.md
Name: texture_buffer_nd

Overview:
Parametrised successor texture buffer for the rasteriser's texturing stage. It stores one RGBA4444 texture streamed over AXI-Stream and serves one texel per clock to the texel pipeline, with fixed 2-cycle latency. Relative to the current texture buffer it adds:
- independent power-of-two width and height (non-square, up to 256x256);
- per-axis wrap/clamp;
- overflow protection on the write stream;
- a load-status handshake.

Parameters:
STREAM_WIDTH, 64, write-port width in bits; multiple of 16, range 16..256; PPB = STREAM_WIDTH/16 texels per beat.
SIZE, 17, memory size in bytes as log2; DEPTH = 2^SIZE / (STREAM_WIDTH/8) beats.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-high reset.
widthLog2  in  4  texture width log2, 0..8.
heightLog2  in  4  texture height log2, 0..8.
clampS  in  1  1 = clamp S, 0 = wrap S.
clampT  in  1  1 = clamp T, 0 = wrap T.
texelReq  in  1  read request qualifier.
texelIndex  in  32  [31:16] = T, [15:0] = S; unsigned Q1.15.
texel  out  16  RGBA4444 texel.
texelValid  out  1  texel valid, 2 cycles after texelReq.
textureReady  out  1  a complete texture is resident.
overflow  out  1  last stream exceeded DEPTH beats.
s_axis_tvalid  in  1  stream valid.
s_axis_tready  out  1  stream ready.
s_axis_tlast  in  1  last beat of texture.
s_axis_tdata  in  STREAM_WIDTH  texels; lane 0 = lowest texel address.

Behaviour:
- Reset (async assert, sync deassert inside the clk domain):
  - writeAddr = 0, state = IDLE, s_axis_tready = 1;
  - textureReady = 0, overflow = 0;
  - texelValid = 0, texel = 0;
  - read pipeline cleared.
- Config inputs are static while texelReq traffic is in flight. widthLog2 + heightLog2 must not exceed SIZE - 1; otherwise the read address wraps modulo memory size.
- Coordinate mapping, cycle 0, combinational, per axis with log2 n:
  - wrap: int = coord[15-n +: n], which drops the integer bit.
  - clamp: if coord[15] = 1, int = 2^n - 1; else int = coord[15-n +: n].
  - n = 0 gives int = 0.
- Linear index = (tInt << widthLog2) | sInt, SIZE-1 bits. wordAddr = index >> log2(PPB); lane = index[log2(PPB)-1:0].
- Read pipeline:
  - cycle 0: address presented to a synchronous RAM;
  - cycle 1: RAM data and the registered lane are available;
  - cycle 2: texel = selected lane (registered) and texelValid = registered texelReq delayed 2.
  - One request per cycle, no stalls. texel holds its last value when texelValid = 0.
- RAM is read-first: a read and a write to the same word in the same cycle return the old data.
- Write FSM. A beat is accepted when s_axis_tvalid && s_axis_tready.
  - IDLE:
    - s_axis_tready = 1.
    - Accepted beat: write at writeAddr; textureReady <= 0; overflow <= 0.
    - If tlast on that beat: writeAddr <= 0, textureReady <= 1, stay IDLE.
    - Otherwise: writeAddr <= 1, go to LOAD.
  - LOAD:
    - Accepted beat: write at writeAddr.
    - tlast: writeAddr <= 0, textureReady <= 1, go to IDLE.
    - Else if writeAddr = DEPTH-1: overflow <= 1, go to DRAIN.
    - Else writeAddr++.
  - DRAIN:
    - s_axis_tready = 1; beats are discarded (no RAM write).
    - On tlast: writeAddr <= 0, textureReady <= 1, go to IDLE. overflow stays set until the next stream starts.
  - s_axis_tready is always 1 outside reset; the block never backpressures.
- Reads during LOAD/DRAIN are allowed and return mixed old/new contents; textureReady = 0 flags this.
- Reset mid-stream: the FSM returns to IDLE. The remaining beats of the interrupted stream are treated as a new texture.

Test Plan:
1. STREAM_WIDTH=64, SIZE=17, 32x32 (widthLog2=5, heightLog2=5); stream 256 beats with texel value = address, tlast on beat 256 -> textureReady=1 the cycle after the last beat, overflow=0. texelIndex = {16'h2000, 16'h4000} (t=0.25, s=0.5) -> texel = 16'd272, texelValid exactly 2 cycles after texelReq.
2. Same texture, S = 16'h8400:
   - clampS=0 -> sInt=1;
   - clampS=1 -> sInt=31.
   With T = 0 this gives texel = 1 and 31 respectively.
3. Non-square 64x16 (6, 4), T = 16'h7800 (t = 15/16), S = 0 -> index 960 -> texel 960. clampT=1 with T = 16'hFFFF -> tInt=15.
4. Overflow: SIZE=11 (DEPTH=256), stream 300 beats with tlast on beat 300:
   - overflow=1 from the cycle after beat 256;
   - RAM word 0 is unchanged by beats 257..300;
   - textureReady=1 after tlast.
   Next single-beat stream -> overflow cleared.
5. Assert reset asynchronously (between edges) during LOAD at writeAddr=100 -> outputs immediately at reset values. After release, a 256-beat stream writes from word 0.
6. Back-to-back texelReq for 8 cycles with distinct indices, interleaved with a concurrent write to the same word -> 8 consecutive texelValid pulses in order, with read-first data on the collision cycle.
